// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite definitions for the SRAM slave.
//   ahbl_state_t : slave data-phase FSM encoding
//   HTRANS_* / HSIZE_* / HRESP_* : bus field encodings
//   xfer_legal() : size/alignment legality of an address phase
package ahbl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_LAST = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } ahbl_state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Only naturally aligned byte/halfword/word transfers are supported.
  function automatic logic xfer_legal(input logic [2:0] size, input logic [1:0] addr);
    logic ok;
    case (size)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = ~addr[0];
      HSIZE_WORD: ok = (addr == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ms_sram_1rw.sv
// Single-port 32-bit SRAM with per-byte write enables and asynchronous read.
//   HCLK  : write clock
//   be    : byte-lane write enables, lane 0 = bits [7:0]
//   addr  : word address
//   wdata : write data (lane-aligned)
//   rdata : combinational read of mem[addr]
// Contents are deliberately not reset.
module ms_sram_1rw
  import ahbl_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          HCLK,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];

  always_ff @(posedge HCLK) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ms_ahbl_sram.sv
// AHB-Lite SRAM slave with a fixed number of wait states per OKAY transfer
// and a two-cycle ERROR response for illegal size/alignment.
//   HCLK, HRESET (sync, active-high)
//   HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY : AHB-Lite slave inputs
//   HREADYOUT, HRESP, HRDATA                           : AHB-Lite slave outputs
//
// state | meaning
// IDLE  | no data phase in flight, zero-wait OKAY
// WAIT  | OKAY data phase stalled, wait counter running down
// LAST  | final OKAY cycle: write commits / read data driven
// ERR1  | first ERROR cycle, HREADYOUT low
// ERR2  | second ERROR cycle, HREADYOUT high
module ms_ahbl_sram
  import ahbl_pkg::*;
#(
  parameter int AW = 10,
  parameter int WS = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam logic [2:0] WS_CNT = 3'(WS);

  ahbl_state_t   state_q, state_d;
  logic [2:0]    wait_cnt_q, wait_cnt_d;
  logic [AW+1:0] addr_q;
  logic          write_q;
  logic [2:0]    size_q;

  logic          trans_active;
  logic          addr_phase;
  logic          ap_legal;
  logic [3:0]    lane_be;
  logic [3:0]    sram_be;
  logic [31:0]   sram_rdata;
  logic          unused_haddr;

  assign unused_haddr = ^HADDR[31:AW+2];

  always_comb begin
    trans_active = 1'b0;
    case (HTRANS)
      HTRANS_NONSEQ, HTRANS_SEQ: trans_active = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  trans_active = 1'b0;
      default:                   trans_active = 1'b0;
    endcase
  end

  // Address phases are only taken in states that drive HREADYOUT high.
  assign addr_phase = HSEL & HREADY & trans_active &
                      ((state_q == ST_IDLE) | (state_q == ST_LAST) | (state_q == ST_ERR2));
  assign ap_legal   = xfer_legal(HSIZE, HADDR[1:0]);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    HREADYOUT  = 1'b1;
    HRESP      = HRESP_OKAY;
    case (state_q)
      ST_IDLE, ST_LAST, ST_ERR2: begin
        if (state_q == ST_ERR2) HRESP = HRESP_ERROR;
        if (addr_phase) begin
          if (!ap_legal) begin
            state_d = ST_ERR1;
          end else if (WS_CNT != 3'd0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WS_CNT;
          end else begin
            state_d = ST_LAST;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        HREADYOUT  = 1'b0;
        wait_cnt_d = wait_cnt_q - 3'd1;
        if (wait_cnt_q == 3'd1) state_d = ST_LAST;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 3'd0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      size_q     <= HSIZE_BYTE;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (addr_phase) begin
        addr_q  <= HADDR[AW+1:0];
        write_q <= HWRITE;
        size_q  <= HSIZE;
      end
    end
  end

  // Little-endian lane selection from the registered size and low address bits.
  always_comb begin
    lane_be = 4'b0000;
    case (size_q)
      HSIZE_BYTE: lane_be = 4'b0001 << addr_q[1:0];
      HSIZE_HALF: lane_be = addr_q[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: lane_be = 4'b1111;
      default:    lane_be = 4'b0000;
    endcase
  end

  // The write lands on the LAST edge, so a read accepted in that same cycle
  // sees the new word through the asynchronous read port.
  assign sram_be = ((state_q == ST_LAST) && write_q) ? lane_be : 4'b0000;
  assign HRDATA  = (state_q == ST_LAST) ? sram_rdata : 32'h0;

  ms_sram_1rw #(.AW(AW)) u_sram (
    .HCLK  (HCLK),
    .be    (sram_be),
    .addr  (addr_q[AW+1:2]),
    .wdata (HWDATA),
    .rdata (sram_rdata)
  );

endmodule

// File: tb/tb_ms_ahbl_sram.sv
// Scoreboard bench for ms_ahbl_sram: one instance with 2 wait states and one
// with none, each with its own bus. The driver pushes the expected response
// for every accepted address phase; a negedge monitor pops and compares.
module tb_ms_ahbl_sram;

  typedef struct {
    bit          err;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel   [2];
  logic [31:0] haddr  [2];
  logic [1:0]  htrans [2];
  logic        hwrite [2];
  logic [2:0]  hsize  [2];
  logic [31:0] hwdata [2];
  logic        rdy0, rdy1, rsp0, rsp1;
  logic [31:0] rd0, rd1;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cur      = 0;
  bit          mon_en   = 1'b0;
  int          ws_of [2];
  logic [31:0] mdl [2][16];
  exp_t        q [$];

  always #5 hclk = ~hclk;

  ms_ahbl_sram #(.AW(10), .WS(2)) u_ws2 (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel[0]), .HADDR(haddr[0]),
    .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HWDATA(hwdata[0]),
    .HREADY(rdy0), .HREADYOUT(rdy0), .HRESP(rsp0), .HRDATA(rd0)
  );

  ms_ahbl_sram #(.AW(10), .WS(0)) u_ws0 (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel[1]), .HADDR(haddr[1]),
    .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HWDATA(hwdata[1]),
    .HREADY(rdy1), .HREADYOUT(rdy1), .HRESP(rsp1), .HRDATA(rd1)
  );

  function automatic logic rdy_of(input int k);
    return (k == 1) ? rdy1 : rdy0;
  endfunction
  function automatic logic rsp_of(input int k);
    return (k == 1) ? rsp1 : rsp0;
  endfunction
  function automatic logic [31:0] rdata_of(input int k);
    return (k == 1) ? rd1 : rd0;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut_ws=%0d t=%0t got=%h expected=%h", nm, ws_of[cur], $time, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge hclk);
    #1;
  endtask

  // Reference: legal iff size <= word and address is a multiple of the size.
  task automatic issue(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd);
    int   k, g, idx, nb, lane;
    bit   legal;
    exp_t e;
    k = cur;
    hsel[k] = 1'b1; htrans[k] = 2'b10; haddr[k] = a; hwrite[k] = wr; hsize[k] = sz;
    g = 0;
    while (!rdy_of(k) && g < 32) begin
      @(posedge hclk); #1;
      g++;
    end
    if (g >= 32) check("addr_phase_timeout", 32'(g), 32'd0);
    @(posedge hclk); #1;
    hwdata[k] = wd;
    hsel[k] = 1'b0; htrans[k] = 2'b00;
    legal = (sz <= 3'd2) && ((int'(a[5:0]) % (1 << int'(sz))) == 0);
    idx   = int'(a[5:2]);
    e.err = !legal;
    e.rd  = !wr;
    e.data = mdl[k][idx];
    if (legal && wr) begin
      nb = 1 << int'(sz);
      for (int i = 0; i < nb; i++) begin
        lane = int'(a[1:0]) + i;
        mdl[k][idx][lane*8 +: 8] = wd[lane*8 +: 8];
      end
    end
    q.push_back(e);
  endtask

  task automatic idle_gap(input int n);
    hsel[cur]   = 1'($urandom_range(0, 1));
    htrans[cur] = 2'($urandom_range(0, 1));
    tick(n);
    hsel[cur] = 1'b0; htrans[cur] = 2'b00;
  endtask

  task automatic drain();
    hsel[cur] = 1'b0; htrans[cur] = 2'b00;
    tick(8);
  endtask

  // Monitor: tracks data phases from bus activity and checks each response.
  bit   in_data = 1'b0;
  int   wcnt = 0;
  exp_t mexp;
  always @(negedge hclk) begin
    if (!mon_en) begin
      in_data = 1'b0;
      wcnt    = 0;
    end else begin
      if (in_data) begin
        if (q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
          in_data = 1'b0;
        end else if (!rdy_of(cur)) begin
          wcnt++;
          check("wait_hresp", 32'(rsp_of(cur)), 32'(q[0].err));
          check("wait_hrdata", rdata_of(cur), 32'h0);
          if (wcnt > 16) begin
            check("data_phase_timeout", 32'(wcnt), 32'd0);
            void'(q.pop_front());
            in_data = 1'b0;
          end
        end else begin
          mexp = q.pop_front();
          check("hresp", 32'(rsp_of(cur)), 32'(mexp.err));
          check("wait_states", 32'(wcnt), mexp.err ? 32'd1 : 32'(ws_of[cur]));
          if (mexp.err) check("err_hrdata", rdata_of(cur), 32'h0);
          else if (mexp.rd) check("rdata", rdata_of(cur), mexp.data);
          in_data = 1'b0;
        end
      end else begin
        check("idle_hreadyout", 32'(rdy_of(cur)), 32'd1);
        check("idle_hresp", 32'(rsp_of(cur)), 32'd0);
        check("idle_hrdata", rdata_of(cur), 32'h0);
      end
      if (hsel[cur] && rdy_of(cur) && htrans[cur][1]) begin
        in_data = 1'b1;
        wcnt    = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [5:0]  off;
    logic [2:0]  sz;
    ws_of[0] = 2; ws_of[1] = 0;
    for (int k = 0; k < 2; k++) begin
      hsel[k] = 1'b0; htrans[k] = 2'b00; haddr[k] = '0;
      hwrite[k] = 1'b0; hsize[k] = 3'd0; hwdata[k] = '0;
    end
    hreset = 1'b1;
    tick(3);
    for (int k = 0; k < 2; k++) begin
      cur = k;
      check("rst_hreadyout", 32'(rdy_of(k)), 32'd1);
      check("rst_hresp", 32'(rsp_of(k)), 32'd0);
      check("rst_hrdata", rdata_of(k), 32'h0);
    end
    hreset = 1'b0;
    tick(1);
    mon_en = 1'b1;

    // Give every word in the test window a known value.
    for (int k = 0; k < 2; k++) begin
      cur = k;
      for (int w = 0; w < 16; w++) issue(1'b1, 32'(w * 4), 3'd2, $urandom);
      drain();
    end

    // Two wait states: word write then read back; misaligned word; HSIZE=3.
    cur = 0;
    issue(1'b1, 32'h10, 3'd2, 32'h11223344);
    issue(1'b0, 32'h10, 3'd2, 32'h0);
    issue(1'b1, 32'h02, 3'd2, 32'hFFFF_FFFF);
    issue(1'b0, 32'h00, 3'd2, 32'h0);
    issue(1'b0, 32'h04, 3'd3, 32'h0);
    issue(1'b0, 32'h10, 3'd2, 32'h0);
    drain();

    // Zero wait states: byte write into a cleared word, read back-to-back.
    cur = 1;
    issue(1'b1, 32'h10, 3'd2, 32'h0);
    issue(1'b1, 32'h13, 3'd0, 32'hAA00_0000);
    issue(1'b0, 32'h10, 3'd2, 32'h0);
    issue(1'b1, 32'h16, 3'd1, 32'hBEEF_0000);
    issue(1'b0, 32'h14, 3'd2, 32'h0);
    drain();

    for (int k = 0; k < 2; k++) begin
      cur = k;
      for (int n = 0; n < 150; n++) begin
        r   = $urandom;
        sz  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        off = 6'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0 && sz <= 3'd2) off = off & ~6'((1 << int'(sz)) - 1);
        issue(1'($urandom_range(0, 1)), {r[31:12], 6'b0, off}, sz, $urandom);
        if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 3));
      end
      drain();
    end

    // Reset during the wait states of a write must discard it.
    cur = 0;
    issue(1'b1, 32'h20, 3'd2, 32'h5566_7788);
    drain();
    mon_en = 1'b0;
    tick(1);
    hsel[0] = 1'b1; htrans[0] = 2'b10; haddr[0] = 32'h20; hwrite[0] = 1'b1; hsize[0] = 3'd2;
    tick(1);
    hsel[0] = 1'b0; htrans[0] = 2'b00; hwdata[0] = 32'hDEAD_BEEF;
    check("in_wait_hreadyout", 32'(rdy0), 32'd0);
    hreset = 1'b1;
    tick(1);
    check("rst_wait_hreadyout", 32'(rdy0), 32'd1);
    check("rst_wait_hresp", 32'(rsp0), 32'd0);
    check("rst_wait_hrdata", rd0, 32'h0);
    hreset = 1'b0;
    tick(4);
    check("post_rst_hreadyout", 32'(rdy0), 32'd1);
    mon_en = 1'b1;
    tick(1);
    issue(1'b0, 32'h20, 3'd2, 32'h0);
    drain();

    check("sb_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ms_ahbl_sram.md
MS_AHBL_SRAM -- requirements
Module: ms_ahbl_sram

Interface
REQ-001 Parameter AW, default 10: word-address width; memory holds 2**AW 32-bit words.
REQ-002 Parameter WS, default 1, range 0..7: wait states inserted in every OKAY data phase.
REQ-003 Port HCLK input 1: single clock; all logic on rising edge.
REQ-004 Port HRESET input 1: reset, synchronous and active-high.
REQ-005 Port HSEL input 1: slave select.
REQ-006 Port HADDR input 32: byte address; only HADDR[AW+1:0] decoded.
REQ-007 Port HTRANS input 2: transfer type; NONSEQ/SEQ active, IDLE/BUSY inactive.
REQ-008 Port HWRITE input 1: 1 = write.
REQ-009 Port HSIZE input 3: 0 byte, 1 halfword, 2 word.
REQ-010 Port HWDATA input 32: write data, valid in data phase.
REQ-011 Port HREADY input 1: bus-level ready; address phase accepted only when high.
REQ-012 Port HREADYOUT output 1: this slave's ready.
REQ-013 Port HRESP output 1: 0 OKAY, 1 ERROR.
REQ-014 Port HRDATA output 32: read data.

Function
REQ-015 Address phase accepted when HSEL & HREADY & HTRANS[1]; HADDR, HWRITE, HSIZE registered.
REQ-016 FSM states: IDLE, WAIT, LAST, ERR1, ERR2.
REQ-017 IDLE: HREADYOUT=1, HRESP=0; on accept go WAIT (WS>0, load wait counter with WS), LAST (WS=0), or ERR1 (illegal).
REQ-018 Illegal transfer: HSIZE>2, halfword with HADDR[0]=1, or word with HADDR[1:0]!=0.
REQ-019 WAIT: HREADYOUT=0, HRESP=0, counter decrements each cycle; at 1 go LAST.
REQ-020 LAST: HREADYOUT=1, HRESP=0; transfer completes this cycle; next state IDLE, or a new accepted address phase restarts as REQ-017.
REQ-021 ERR1: HREADYOUT=0, HRESP=1, no wait states; always go ERR2.
REQ-022 ERR2: HREADYOUT=1, HRESP=1; no memory write; accepts new address phase as REQ-017.
REQ-023 Write commits on the LAST-cycle edge, only byte lanes selected by registered HSIZE and HADDR[1:0] (little-endian).
REQ-024 Read: HRDATA = full word at registered address during LAST; masking of unused lanes is the master's job.
REQ-025 Outside LAST, HRDATA = 32'h0.
REQ-026 A read whose address phase coincides with the LAST cycle of a write to the same word returns the newly written data (no forwarding gap).
REQ-027 Total OKAY latency: WS+1 data-phase cycles; back-to-back transfers with no idle cycle between.
REQ-028 IDLE/BUSY or HSEL=0 during LAST/ERR2 → IDLE with zero-wait OKAY behaviour.

Reset
REQ-029 HRESET high: state IDLE, counter 0, HREADYOUT=1, HRESP=0, HRDATA=0, registered address-phase cleared; pending write discarded.
REQ-030 Memory contents are not reset.

Structure
REQ-031 State encoding, HSIZE/HTRANS encodings and OKAY/ERROR constants live in shared package ahbl_pkg.
REQ-032 Storage is sub-module ms_sram_1rw (byte-write-enable, async read, AW parameter); FSM and lane decode stay in ms_ahbl_sram.

Verification
REQ-033 WS=2, word write 0x11223344 @0x10, then read @0x10 → each data phase 2 cycles HREADYOUT=0, read HRDATA=0x11223344, HRESP=0.
REQ-034 WS=0, byte write 0xAA @0x13 to word 0x00000000, immediate read @0x10 → 0xAA000000 with no idle cycle.
REQ-035 Word access @0x02 → ERR1 (HREADYOUT=0,HRESP=1) then ERR2 (HREADYOUT=1,HRESP=1); memory unchanged.
REQ-036 HSIZE=3 read → two-cycle ERROR; HRDATA=0.
REQ-037 HRESET asserted in WAIT of a write → next cycle HREADYOUT=1,HRESP=0; later read of that address returns old data.
